hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 16 +
 rtl/hazard_unit_forward.sv | 23 ++
 rtl/hazard_unit.sv | 137 +++++++++++++
 tb/tb_hazard_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline encodings: forwarding selects, memory-FSM states and the load ResultSrc code.
package hazard_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // ResultSrcE value that marks a load in Execute; LoadE is derived from it upstream.
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/hazard_unit_forward.sv
// Per-operand forwarding select; purely combinational, Memory-stage result wins over Writeback.
module forward_unit
  import hazard_unit_pkg::*;
(
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    // x0 is hardwired to zero, so a write to it must never be forwarded.
    if (reg_write_m_i && (rs_e_i != 5'd0) && (rd_m_i == rs_e_i)) begin
      fwd_o = FWD_MEM;
    end else if (reg_write_w_i && (rs_e_i != 5'd0) && (rd_w_i == rs_e_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: operand forwarding, load-use/branch stall-flush, and a data-memory wait FSM
// with timeout. State updates on the falling clock edge to line up with the pipeline registers.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       LoadE,
  input  logic       PCSrcE,
  input  logic       MemAccessM,
  input  logic       mem_ready,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       mem_req,
  output logic       mem_err
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic             lw_stall;
  logic             mem_stall;

  forward_unit u_fwd_a (
    .rs_e_i        (Rs1E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardAE)
  );

  forward_unit u_fwd_b (
    .rs_e_i        (Rs2E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardBE)
  );

  assign lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    mem_stall  = 1'b0;
    mem_req    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (MemAccessM) begin
          mem_stall  = 1'b1;
          mem_req    = 1'b1;
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        mem_req = 1'b1;
        // A completion arriving on the limit cycle is a success, not a timeout.
        if (mem_ready) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == CNT_MAX) begin
          state_d   = ST_IDLE;
          mem_err_d = 1'b1;
        end else begin
          mem_stall  = 1'b1;
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!reset) begin
      mem_stall = 1'b0;
      mem_req   = 1'b0;
    end
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (!reset) begin
      StallF = 1'b0;
    end else if (mem_stall) begin
      // Freezing the whole pipe takes precedence; flushing now would lose the held instructions.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else begin
      StallF = lw_stall;
      StallD = lw_stall;
      FlushD = PCSrcE;
      FlushE = lw_stall | PCSrcE;
    end
  end

  assign mem_err = mem_err_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: forwarding, load-use, branch flush, memory wait/timeout, reset.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MemAccessM, mem_ready;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, mem_req, mem_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] req_pat, stl_pat;
  int         stall_n;
  bit         done;

  wire [5:0] ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE};
  wire       all_stall = StallF & StallD & StallE & StallM;

  always #5 clk = ~clk;

  hazard_unit #(.MAX_WAIT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .LoadE      (LoadE),
    .PCSrcE     (PCSrcE),
    .MemAccessM (MemAccessM),
    .mem_ready  (mem_ready),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .mem_req    (mem_req),
    .mem_err    (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive just after the active (falling) edge; checks follow at the next rising edge.
  task automatic drive_slot();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    Rs1D = 5'd0; Rs2D = 5'd3; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd3; RdM = 5'd0; RdW = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    LoadE = 1'b1; PCSrcE = 1'b1; MemAccessM = 1'b1; mem_ready = 1'b0;

    @(posedge clk);
    chk("rst_ctl", 32'(ctl), 32'(6'b000000));
    chk("rst_mem_req", 32'(mem_req), 32'(1'b0));
    chk("rst_mem_err", 32'(mem_err), 32'(1'b0));

    drive_slot();
    LoadE = 1'b0; PCSrcE = 1'b0; MemAccessM = 1'b0; Rs2D = 5'd0; RdE = 5'd0;
    #1 reset = 1'b1;

    // Forwarding, combinational
    drive_slot();
    RdM = 5'd5; RdW = 5'd5; Rs1E = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
    #1 chk("fwdA_mem_prio", 32'(ForwardAE), 32'(2'b10));
    RegWriteM = 1'b0;
    #1 chk("fwdA_wb", 32'(ForwardAE), 32'(2'b01));
    RdM = 5'd0; Rs1E = 5'd0; RegWriteM = 1'b1; RdW = 5'd0;
    #1 chk("fwdA_x0", 32'(ForwardAE), 32'(2'b00));
    Rs2E = 5'd7; RdM = 5'd6; RdW = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1;
    #1 chk("fwdB_wb", 32'(ForwardBE), 32'(2'b01));
    RdM = 5'd7;
    #1 chk("fwdB_mem", 32'(ForwardBE), 32'(2'b10));
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    #1 chk("fwdB_none", 32'(ForwardBE), 32'(2'b00));

    // Load-use, then release
    drive_slot();
    LoadE = 1'b1; RdE = 5'd3; Rs2D = 5'd3;
    @(posedge clk) chk("lw_stall", 32'(ctl), 32'(6'b110001));
    drive_slot();
    LoadE = 1'b0;
    @(posedge clk) chk("lw_release", 32'(ctl), 32'(6'b000000));
    drive_slot();
    LoadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    @(posedge clk) chk("lw_x0_no_stall", 32'(ctl), 32'(6'b000000));

    // Load-use with taken branch, then branch alone
    drive_slot();
    LoadE = 1'b1; RdE = 5'd4; Rs1D = 5'd4; PCSrcE = 1'b1;
    @(posedge clk) chk("lw_and_branch", 32'(ctl), 32'(6'b110011));
    drive_slot();
    LoadE = 1'b0;
    @(posedge clk) chk("branch_only", 32'(ctl), 32'(6'b000011));
    drive_slot();
    PCSrcE = 1'b0; Rs1D = 5'd0; RdE = 5'd0;
    @(posedge clk) chk("quiet", 32'(ctl), 32'(6'b000000));

    // Memory access, ready on 3rd WAIT cycle; hazards mixed in during the stall
    req_pat = '0; stl_pat = '0;
    for (int i = 0; i < 6; i++) begin
      drive_slot();
      MemAccessM = (i <= 3); mem_ready = (i == 3);
      LoadE = (i == 1); RdE = 5'd3; Rs2D = 5'd3; PCSrcE = (i == 1);
      @(posedge clk);
      req_pat[i] = mem_req;
      stl_pat[i] = all_stall;
      if (i == 1) chk("memstall_overrides_flush", 32'(ctl), 32'(6'b111100));
    end
    chk("wait3_req_pattern", 32'(req_pat), 32'(6'b001111));
    chk("wait3_stall_pattern", 32'(stl_pat), 32'(6'b000111));
    chk("wait3_no_err", 32'(mem_err), 32'(1'b0));

    // Back-to-back accesses each completing on the first WAIT cycle
    req_pat = '0; stl_pat = '0;
    for (int i = 0; i < 5; i++) begin
      drive_slot();
      MemAccessM = (i <= 3); mem_ready = (i == 1) || (i == 3);
      @(posedge clk);
      req_pat[i] = mem_req;
      stl_pat[i] = all_stall;
    end
    chk("b2b_req_pattern", 32'(req_pat), 32'(6'b001111));
    chk("b2b_stall_pattern", 32'(stl_pat), 32'(6'b000101));

    // Timeout
    drive_slot();
    MemAccessM = 1'b1; mem_ready = 1'b0;
    stall_n = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      if (StallF) stall_n++;
      else done = 1'b1;
      if (!done) drive_slot();
    end
    chk("timeout_stall_cycles", 32'(stall_n), 32'd16);
    chk("timeout_req_at_limit", 32'(mem_req), 32'(1'b1));
    chk("timeout_err_not_yet", 32'(mem_err), 32'(1'b0));
    drive_slot();
    MemAccessM = 1'b0;
    @(posedge clk);
    chk("timeout_err_set", 32'(mem_err), 32'(1'b1));
    chk("timeout_idle", 32'(mem_req), 32'(1'b0));

    // Sticky error across a successful minimum-latency access
    drive_slot();
    MemAccessM = 1'b1;
    @(posedge clk) chk("min_lat_req_cycle", 32'(ctl), 32'(6'b111100));
    drive_slot();
    mem_ready = 1'b1;
    @(posedge clk) chk("min_lat_wait_no_stall", 32'({mem_req, ctl}), 32'(7'b1000000));
    drive_slot();
    MemAccessM = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    chk("err_sticky", 32'(mem_err), 32'(1'b1));
    chk("after_min_lat_idle", 32'(mem_req), 32'(1'b0));

    // Reset asserted mid-WAIT
    drive_slot();
    MemAccessM = 1'b1;
    drive_slot();
    @(posedge clk) chk("midwait_req", 32'({mem_req, StallM}), 32'(2'b11));
    #1 reset = 1'b0;
    #1;
    chk("rst_midwait_req", 32'(mem_req), 32'(1'b0));
    chk("rst_midwait_ctl", 32'(ctl), 32'(6'b000000));
    chk("rst_midwait_err", 32'(mem_err), 32'(1'b0));
    drive_slot();
    MemAccessM = 1'b0;
    reset = 1'b1;
    @(posedge clk) chk("post_rst_idle", 32'(mem_req), 32'(1'b0));
    drive_slot();
    MemAccessM = 1'b1;
    @(posedge clk) chk("post_rst_request", 32'({mem_req, ctl}), 32'(7'b1111100));
    drive_slot();
    mem_ready = 1'b1;
    @(posedge clk) chk("post_rst_wait_done", 32'({mem_req, ctl}), 32'(7'b1000000));
    drive_slot();
    MemAccessM = 1'b0; mem_ready = 1'b0;
    @(posedge clk) chk("post_rst_final", 32'({mem_req, mem_err}), 32'(2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
